// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared SPI definitions used by the SPI master, the SPI slave and the receive
// FIFO. The frame type keeps every block that moves SPI words at one width.
//   SPI_FRAME_W : bits per SPI frame
//   spi_frame_t : one received or transmitted frame, LSB = first bit on the wire
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_FRAME_W = 12;

  typedef logic [SPI_FRAME_W-1:0] spi_frame_t;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// N-flop single-bit synchronizer bringing a level from the sclk domain into clk.
//   clk : destination clock (rising edge)
//   rst : synchronous active-high reset, clears every stage to 0
//   d_i : asynchronous input level
//   q_o : synchronized level, N clk edges behind d_i
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule : spi_sync

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
// Receive-side FIFO between an SPI slave (sclk domain) and a clk-domain consumer.
// The slave's frame-complete level is synchronized, its rising edge pushes the
// current data_in word, and the consumer drains words through a show-ahead
// valid/ready port. Frames arriving while full are dropped and flagged.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   done_in             : frame-complete level from the slave (asynchronous)
//   data_in             : received frame, stable while done_in is high
//   m_valid / m_ready   : head-entry handshake (pop when both high)
//   m_data              : oldest stored frame, 0 when empty
//   level, full, empty  : occupancy status
//   overflow / ovf_clr  : sticky dropped-frame flag and its clear
//   frame_cnt           : accepted-push counter (only with SPI_RX_STATS_EN)
//
// Build option: define SPI_RX_STATS_EN to add the frame_cnt output.
// -----------------------------------------------------------------------------
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_in,
  input  spi_frame_t               data_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output spi_frame_t               m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]              frame_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic                   done_sync;
  logic                   hist_q, hist_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  spi_frame_t             mem_q [DEPTH];

  logic push_req, pop, is_full, push_ok, drop;

  spi_sync #(
    .N (SYNC_STAGES)
  ) u_done_sync (
    .clk (clk),
    .rst (rst),
    .d_i (done_in),
    .q_o (done_sync)
  );

  assign push_req = done_sync & ~hist_q;
  assign is_full  = (level_q == DEPTH_L);
  assign pop      = m_valid & m_ready;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_ok  = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  always_comb begin
    settle_d = settle_q >> 1;
    // The synchronizer restarts from 0 after reset, so its output reads low for
    // a few cycles even if done_in never fell. While those reset zeros are still
    // in flight the history flop keeps its 1, otherwise a done_in held high
    // across reset would look like a fresh rising edge.
    hist_d   = done_sync | (hist_q & (|settle_q));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop on the same cycle as a clear wins, so no dropped frame goes unseen.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= 1'b1;
      settle_q <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      settle_q <= settle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Frame storage carries no reset; emptiness is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign m_valid  = (level_q != '0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign full     = is_full;
  assign empty    = (level_q == '0);
  assign overflow = ovf_q;

`ifdef SPI_RX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (push_ok) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule : spi_rx_fifo

// File: doc/spi_rx_fifo.md
SPI_RX_FIFO -- requirements
Module: spi_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of frame entries; it SHALL be a power of two, >= 2.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on done_in; minimum 2.
REQ-003 Port clk, input, 1: system clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port done_in, input, 1: SPI slave frame-complete level, asynchronous to clk (sclk domain).
REQ-006 Port data_in, input, 12: SPI slave received frame, stable while done_in is high.
REQ-007 Port m_valid, output, 1: head entry available.
REQ-008 Port m_ready, input, 1: consumer accepts the head entry.
REQ-009 Port m_data, output, 12: head entry, LSB = first bit received.
REQ-010 Port level, output, $clog2(DEPTH)+1: current occupancy.
REQ-011 Ports full and empty, output, 1 each: level==DEPTH and level==0.
REQ-012 Port overflow, output, 1: sticky frame-dropped flag.
REQ-013 Port ovf_clr, input, 1: clears overflow.

Function
REQ-014 done_in SHALL pass through SYNC_STAGES flops; a push SHALL occur on the clk cycle in which the synchronized done shows a 0->1 transition.
REQ-015 The push SHALL sample data_in directly on that cycle; no other sampling of data_in SHALL occur.
REQ-016 A done_in high held for many cycles SHALL produce exactly one push.
REQ-017 From the empty state, m_valid SHALL rise no later than SYNC_STAGES+2 clk edges after done_in rises.
REQ-018 The FIFO SHALL be show-ahead: m_data SHALL equal the oldest entry whenever m_valid=1.
REQ-019 A pop SHALL occur on a cycle where m_valid=1 and m_ready=1; m_ready with m_valid=0 SHALL be ignored.
REQ-020 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-022 Push and pop on the same cycle SHALL both take effect with level unchanged, including when full.
REQ-023 A push when full without a pop SHALL discard the frame, leave the contents unchanged, and set overflow.
REQ-024 overflow SHALL remain set until ovf_clr=1; if ovf_clr and a new drop occur on the same cycle, overflow SHALL stay 1.
REQ-025 Frame order out SHALL equal frame order in.

Reset
REQ-026 On rst, the pointers, level and overflow SHALL be 0, and m_valid and m_data SHALL be 0.
REQ-027 On rst, the synchronizer flops SHALL be cleared to 0, and the edge-detect history flop SHALL be set to 1, so a done_in held high across reset is not pushed.
REQ-028 On rst asserted mid-operation, all stored frames SHALL be discarded the next cycle.

Configuration
REQ-029 With macro SPI_RX_STATS_EN defined, the block SHALL add output frame_cnt[15:0], which counts accepted pushes and wraps from 0xFFFF to 0; it SHALL be cleared by rst and SHALL NOT count dropped frames.
REQ-030 Without SPI_RX_STATS_EN, frame_cnt and its counter SHALL be absent.

Structure
REQ-031 Package spi_pkg SHALL hold SPI_FRAME_W=12 and typedef spi_frame_t (logic [SPI_FRAME_W-1:0]), shared with the SPI master and slave.
REQ-032 Sub-module spi_sync (parameterized N-flop 1-bit synchronizer) SHALL implement REQ-014.

Verification
REQ-033 One frame: done_in pulse with data_in=12'hA5C, m_ready=1 -> exactly one pop, m_data=12'hA5C, level returns to 0.
REQ-034 Burst: 8 frames 12'h001..12'h008 with m_ready=0 -> full=1, level=8; then m_ready=1 -> frames pop in order 001..008, then empty=1.
REQ-035 Overflow: 9th frame 12'hFFF while full -> overflow=1, contents unchanged; ovf_clr pulse -> overflow=0.
REQ-036 Simultaneous: full FIFO, pop and push of 12'h123 on the same cycle -> level stays 8, overflow=0, 12'h123 emerges last.
REQ-037 Reset: rst asserted with level=5 and done_in held high -> level=0, m_valid=0, no push after rst deasserts until done_in falls and rises again.
REQ-038 Stats (SPI_RX_STATS_EN): 10 frames with 1 dropped -> frame_cnt=9.
